// File: rtl/compressor_tree_pipe.sv
// compressor_tree_pipe
// ---------------------------------------------------------------------------
// Pipelined N:2 carry-save reduction tree for signed operand vectors.
// Each level packs its words into groups of four. A 4:2 compressor (two
// chained 3:2 carry-save adders) reduces each group to two words. A short
// trailing group is padded with zero words. Every level output is
// registered and carries its own valid bit, so the latency is LEVELS cycles.
// Throughput is one vector per cycle.
//
// Optional feature, selected by the macro COMPRESSOR_TREE_CPA_EN:
//   defined   - one more registered stage adds sum+carry. carry_o is then 0
//               and the latency is LEVELS+1.
//   undefined - the outputs stay in redundant (sum, carry) form.
//
// Ports:
//   clk_i    in   clock, all state updates on the rising edge
//   rst_ni   in   asynchronous active-low reset (clears valids and data)
//   flush_i  in   synchronous clear of every valid bit; data is untouched
//   valid_i  in   in_i holds a vector
//   ready_o  out  the tree accepts in_i this cycle
//   in_i     in   NUM_IN signed operands of IN_SIZE bits
//   valid_o  out  sum_o/carry_o hold a result
//   ready_i  in   downstream accepts the result
//   sum_o    out  redundant sum word, OUT_SIZE bits
//   carry_o  out  redundant carry word, already aligned (add directly)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until the
// transfer. valid_o never drops while ready_i is low. Stage k loads when it
// is empty or its content moves on this edge. ready_o is that condition for
// stage 0 and is built combinationally back from ready_i. flush_i overrides
// every transfer, and ready_o is high while flush_i is high.
// ---------------------------------------------------------------------------
module compressor_tree_pipe #(
  parameter  int NUM_IN   = 12,
  parameter  int IN_SIZE  = 18,
  localparam int LEVELS   = $clog2(NUM_IN) - 1,
  localparam int OUT_SIZE = IN_SIZE + 2 * LEVELS
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [IN_SIZE-1:0] in_i [NUM_IN],
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic       [OUT_SIZE-1:0] sum_o,
  output logic       [OUT_SIZE-1:0] carry_o
);

  // Word count entering level k. Every level turns each group of four
  // (zero padded) into two words.
  function automatic int words_at(input int k);
    int n;
    n = NUM_IN;
    for (int j = 0; j < k; j++) begin
      n = 2 * ((n + 3) / 4);
    end
    return n;
  endfunction

`ifdef COMPRESSOR_TREE_CPA_EN
  localparam int NS = LEVELS + 1;  // compressor levels plus the adder stage
`else
  localparam int NS = LEVELS;
`endif

  // ------------------------------------------------------------------
  // Elastic control: one valid bit per registered stage
  // ------------------------------------------------------------------
  logic [NS-1:0] v_q;    // stage holds a vector
  logic [NS-1:0] ld;     // stage may load this edge (empty or draining)
  logic [NS-1:0] vin;    // valid offered to each stage by its producer
  logic [NS-1:0] en;     // stage data registers capture this edge
  logic          ld_acc;

  // ld[k] = !v[k] || ld[k+1], with ld[NS] = ready_i. The chain is written
  // as a running OR from the output end so that no bit of ld reads another
  // bit of ld.
  always_comb begin
    ld_acc = ready_i;
    ld     = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      ld_acc = ld_acc | ~v_q[k];
      ld[k]  = ld_acc;
    end
  end

  always_comb begin
    vin    = '0;
    vin[0] = valid_i;
    for (int k = 1; k < NS; k++) begin
      vin[k] = v_q[k-1];
    end
  end

  // Data moves only on a real handshake and never during a flush. A bubble
  // moving into a stage clears its valid bit and leaves its data alone.
  assign en = vin & ld & {NS{~flush_i}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
    end else if (flush_i) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (ld[k]) begin
          v_q[k] <= vin[k];
        end
      end
    end
  end

  assign ready_o = flush_i | ld[0];
  assign valid_o = v_q[NS-1];

  // ------------------------------------------------------------------
  // Compressor levels
  // ------------------------------------------------------------------
  // All words are carried at the full OUT_SIZE width. The operands are
  // sign-extended once, at the tree input, and every later step is exact
  // modulo 2^OUT_SIZE. Sign-extending the two redundant words of a level on
  // their own would be wrong: each word may wrap even when their sum does
  // not. OUT_SIZE holds the worst-case sum, so the final wrap is harmless.
  for (genvar k = 0; k < LEVELS; k++) begin : lvl
    localparam int NI = words_at(k);
    localparam int NO = words_at(k + 1);

    logic [OUT_SIZE-1:0] dpad [2*NO];  // level input, zero padded to 4s
    logic [OUT_SIZE-1:0] dnx  [NO];    // compressor outputs
    logic [OUT_SIZE-1:0] dq   [NO];    // stage registers

    for (genvar i = 0; i < 2 * NO; i++) begin : g_pad
      if (i >= NI) begin : g_zero
        assign dpad[i] = '0;
      end else if (k == 0) begin : g_in
        assign dpad[i] = {{(OUT_SIZE-IN_SIZE){in_i[i][IN_SIZE-1]}}, in_i[i]};
      end else begin : g_prev
        assign dpad[i] = lvl[k-1].dq[i];
      end
    end

    // 4:2 compressor = two chained 3:2 stages. Each carry is shifted up one
    // bit here, so the two output words line up and can be added directly.
    for (genvar g = 0; g < NO / 2; g++) begin : g_c42
      logic [OUT_SIZE-1:0] a, b, c, d, s1, c1;
      assign a  = dpad[4*g];
      assign b  = dpad[4*g+1];
      assign c  = dpad[4*g+2];
      assign d  = dpad[4*g+3];
      assign s1 = a ^ b ^ c;
      assign c1 = ((a & b) | (a & c) | (b & c)) << 1;
      assign dnx[2*g]   = s1 ^ c1 ^ d;
      assign dnx[2*g+1] = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < NO; i++) begin
          dq[i] <= '0;
        end
      end else if (en[k]) begin
        for (int i = 0; i < NO; i++) begin
          dq[i] <= dnx[i];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------
`ifdef COMPRESSOR_TREE_CPA_EN
  logic [OUT_SIZE-1:0] cpa_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cpa_q <= '0;
    end else if (en[LEVELS]) begin
      cpa_q <= lvl[LEVELS-1].dq[0] + lvl[LEVELS-1].dq[1];
    end
  end

  assign sum_o   = cpa_q;
  assign carry_o = '0;
`else
  assign sum_o   = lvl[LEVELS-1].dq[0];
  assign carry_o = lvl[LEVELS-1].dq[1];
`endif

endmodule
